pocket_video_out: RTL
=====================

Name: pocket_video_out

Overview:
- Downstream of the LCD/video timing stage.
- Consumes its pixel-enable, sync, blank and 8-bit RGB outputs on the video clock.
- Produces the handheld's scaler-facing video stream:
  - single-cycle sync pulses
  - a data-enable gated by the pixel enable
  - zeroed RGB outside active video
  - an end-of-line control word
- Also measures active width/height per frame and flags geometry errors to the system status logic.

Parameters:
- EXP_W, 9'd160: expected active pixels per line (sgb_en=0 geometry).
- EXP_W_SGB, 9'd256: expected active pixels per line when sgb_en=1.
- EXP_H, 9'd144: expected active lines per frame (sgb_en=0).
- EXP_H_SGB, 9'd224: expected active lines per frame (sgb_en=1).
- EOL_WORD, 24'h000002: RGB value driven on the end-of-line marker cycle.

Ports:
- clk_vid in 1: video clock (67.108864 MHz).
- reset in 1: asynchronous, active-high reset.
- ce_pix in 1: pixel clock enable from the timing stage.
- hs in 1: positive horizontal sync level.
- vs in 1: positive vertical sync level.
- hbl in 1: horizontal blank level.
- vbl in 1: vertical blank level.
- sgb_en in 1: selects SGB geometry for checking.
- r in 8, g in 8, b in 8: pixel colour, valid at ce_pix.
- video_rgb out 24: {r,g,b} or control word.
- video_de out 1: data enable.
- video_skip out 1: de high but pixel must not be sampled.
- video_hs out 1: one-clock hsync pulse.
- video_vs out 1: one-clock vsync pulse.
- line_width out 9: active pixel count of the last completed line.
- frame_height out 9: active line count of the last completed frame.
- geom_err out 1: sticky geometry-mismatch flag.
- err_clr in 1: clears geom_err.

Behaviour:
- Reset (async assert, release on clk_vid):
  - all outputs 0; internal edge-detect registers 0; counters 0.
- Sampling: inputs are sampled only on ce_pix cycles into a one-stage pipeline (s_hs, s_vs, s_act = ~hbl & ~vbl, s_rgb). No other cycle updates these registers.
- Output timing: all outputs are registered. Events are decided on the clk_vid cycle after the ce_pix sample, i.e. latency 1 ce period + 1 clk.
- video_de/video_skip:
  - video_de = s_act, held for the whole ce period.
  - video_skip = 1 on every clk where video_de=1 except the first clk after the ce sample. The scaler therefore captures exactly one pixel per ce period.
- video_rgb:
  - s_rgb while s_act=1.
  - EOL_WORD for exactly one clk on the first clk after an s_act 1->0 transition.
  - 24'h0 otherwise.
- video_vs: one-clk pulse on the ce-aligned clk where s_vs rises (0->1). Level-high vs produces only one pulse.
- video_hs:
  - one-clk pulse on s_hs rising.
  - If it would coincide with a video_vs pulse, or with the EOL marker clk, it is deferred by one clk.
  - At most one deferral is pending at a time. A new hs rise while one is pending is dropped.
- Width counter:
  - increments on each ce sample with s_act=1.
  - On the s_act 1->0 transition, line_width <= count and count <= 0.
  - Saturates at 9'h1FF (no wrap).
- Height counter:
  - increments once per line that had count>0.
  - On s_vs rising, frame_height <= height and height <= 0.
  - Saturates at 9'h1FF.
- Geometry check:
  - On the line end, if line_width != (sgb_en ? EXP_W_SGB : EXP_W), set geom_err.
  - On s_vs rising, if height != expected, set geom_err.
  - The first frame after reset is exempt: checking is armed by the first s_vs rise.
  - err_clr=1 clears geom_err; if set and clear occur in the same clk, set wins.
- Blank/LCD-off frames (rgb constant, timing continuing) are checked normally.
- ce_pix stuck low: outputs hold their current values; no new pulses are generated.
- hbl and vbl changing mid-ce period are ignored until the next ce_pix.

Test Plan:
1. Reset asserted mid-line with video_de=1 -> all outputs 0 within the same cycle (async). After release, no hs/vs pulse until the next rising edge is sampled.
2. Standard frame (160x144, ce every 10 clks, sgb_en=0):
   - video_de=1 for 160 ce periods per line; video_skip low for exactly 1 clk per pixel.
   - EOL_WORD appears once per line.
   - line_width=160, frame_height=144, geom_err=0.
3. hs rising on the same ce as vs rising -> video_vs pulse at clk N, video_hs pulse at clk N+1, each exactly 1 clk wide.
4. Second frame with one line of 159 pixels -> geom_err=1 after that line end. It stays 1 across later good frames until err_clr. A simultaneous err_clr and error keeps geom_err=1.
5. sgb_en=1 with a 256x224 frame -> geom_err stays 0. Switching sgb_en=0 on the next frame with 256-wide lines -> geom_err=1 at the first line end.
6. vs held high for 3 lines -> exactly one video_vs pulse; frame_height is latched once.

Source files
------------

// File: rtl/pocket_video_out.sv
// Scaler-facing video formatter: retimes timing-stage outputs into single-cycle
// sync pulses, gated DE/skip, blanked RGB with an EOL marker, and checks geometry.
module pocket_video_out #(
  parameter logic [8:0]  EXP_W     = 9'd160,
  parameter logic [8:0]  EXP_W_SGB = 9'd256,
  parameter logic [8:0]  EXP_H     = 9'd144,
  parameter logic [8:0]  EXP_H_SGB = 9'd224,
  parameter logic [23:0] EOL_WORD  = 24'h000002
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hs,
  input  logic        vs,
  input  logic        hbl,
  input  logic        vbl,
  input  logic        sgb_en,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic [23:0] video_rgb,
  output logic        video_de,
  output logic        video_skip,
  output logic        video_hs,
  output logic        video_vs,
  output logic [8:0]  line_width,
  output logic [8:0]  frame_height,
  output logic        geom_err,
  input  logic        err_clr
);

  typedef enum logic {HS_IDLE, HS_PEND} hs_state_e;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // Sample stage (current and previous ce sample for edge detection)
  logic        s_hs_q, s_hs_d, s_vs_q, s_vs_d, s_act_q, s_act_d;
  logic [23:0] s_rgb_q, s_rgb_d;
  logic        p_hs_q, p_hs_d, p_vs_q, p_vs_d, p_act_q, p_act_d;
  logic        ce_d1_q;

  // Output registers
  logic [23:0] rgb_q, rgb_d;
  logic        de_q, de_d, skip_q, skip_d, hs_q, hs_d, vs_q, vs_d;
  hs_state_e   hs_st_q, hs_st_d;

  // Geometry measurement
  logic [8:0]  wcnt_q, wcnt_d, hcnt_q, hcnt_d;
  logic [8:0]  lw_q, lw_d, fh_q, fh_d;
  logic        armed_q, armed_d, err_q, err_d;

  logic        hs_rise, vs_rise, act_fall, hs_blocked, err_set;
  logic [8:0]  exp_w, exp_h, h_cur;

  always_comb begin
    s_hs_d  = s_hs_q;
    s_vs_d  = s_vs_q;
    s_act_d = s_act_q;
    s_rgb_d = s_rgb_q;
    p_hs_d  = p_hs_q;
    p_vs_d  = p_vs_q;
    p_act_d = p_act_q;
    if (ce_pix) begin
      p_hs_d  = s_hs_q;
      p_vs_d  = s_vs_q;
      p_act_d = s_act_q;
      s_hs_d  = hs;
      s_vs_d  = vs;
      s_act_d = ~hbl & ~vbl;
      s_rgb_d = {r, g, b};
    end
  end

  // Edges are only evaluated on the clk right after a ce sample
  always_comb begin
    hs_rise  = ce_d1_q & s_hs_q & ~p_hs_q;
    vs_rise  = ce_d1_q & s_vs_q & ~p_vs_q;
    act_fall = ce_d1_q & p_act_q & ~s_act_q;
  end

  always_comb begin
    de_d   = s_act_q;
    skip_d = s_act_q & ~ce_d1_q;
    vs_d   = vs_rise;
    if (s_act_q) begin
      rgb_d = s_rgb_q;
    end else if (act_fall) begin
      rgb_d = EOL_WORD;
    end else begin
      rgb_d = '0;
    end
  end

  // hsync yields to vsync and to the EOL marker; one deferral can be pending
  always_comb begin
    hs_st_d    = hs_st_q;
    hs_d       = 1'b0;
    hs_blocked = vs_rise | act_fall;
    case (hs_st_q)
      HS_IDLE: begin
        if (hs_rise) begin
          if (hs_blocked) begin
            hs_st_d = HS_PEND;
          end else begin
            hs_d = 1'b1;
          end
        end
      end
      HS_PEND: begin
        if (!hs_blocked) begin
          hs_d    = 1'b1;
          hs_st_d = HS_IDLE;
        end
      end
      default: hs_st_d = HS_IDLE;
    endcase
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    lw_d    = lw_q;
    fh_d    = fh_q;
    armed_d = armed_q;
    err_set = 1'b0;
    exp_w   = sgb_en ? EXP_W_SGB : EXP_W;
    exp_h   = sgb_en ? EXP_H_SGB : EXP_H;
    // A line ending on the same ce as the vsync rise still belongs to the closing frame
    h_cur   = (act_fall && wcnt_q != '0) ? sat_inc(hcnt_q) : hcnt_q;
    hcnt_d  = h_cur;
    if (ce_d1_q && s_act_q) begin
      wcnt_d = sat_inc(wcnt_q);
    end
    if (act_fall) begin
      lw_d   = wcnt_q;
      wcnt_d = '0;
      if (armed_q && wcnt_q != exp_w) begin
        err_set = 1'b1;
      end
    end
    if (vs_rise) begin
      fh_d    = h_cur;
      hcnt_d  = '0;
      armed_d = 1'b1;
      if (armed_q && h_cur != exp_h) begin
        err_set = 1'b1;
      end
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      s_hs_q  <= 1'b0;
      s_vs_q  <= 1'b0;
      s_act_q <= 1'b0;
      s_rgb_q <= '0;
      p_hs_q  <= 1'b0;
      p_vs_q  <= 1'b0;
      p_act_q <= 1'b0;
      ce_d1_q <= 1'b0;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      skip_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_st_q <= HS_IDLE;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
      lw_q    <= '0;
      fh_q    <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s_hs_q  <= s_hs_d;
      s_vs_q  <= s_vs_d;
      s_act_q <= s_act_d;
      s_rgb_q <= s_rgb_d;
      p_hs_q  <= p_hs_d;
      p_vs_q  <= p_vs_d;
      p_act_q <= p_act_d;
      ce_d1_q <= ce_pix;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      skip_q  <= skip_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hs_st_q <= hs_st_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      lw_q    <= lw_d;
      fh_q    <= fh_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign video_rgb    = rgb_q;
  assign video_de     = de_q;
  assign video_skip   = skip_q;
  assign video_hs     = hs_q;
  assign video_vs     = vs_q;
  assign line_width   = lw_q;
  assign frame_height = fh_q;
  assign geom_err     = err_q;

endmodule
